// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, funct codes,
// datapath mux selects, ALU controls, state codes and the per-state strobe bundle.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 2;
  localparam int unsigned SEL_W   = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_ctrl_t;

  typedef enum logic [SEL_W-1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } src_b_t;

  typedef enum logic [SEL_W-1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_ZERO   = 2'b11
  } pc_src_t;

  // How the ALU operation is chosen in a given state.
  typedef enum logic [1:0] {
    MODE_ADD   = 2'b00,
    MODE_SUB   = 2'b01,
    MODE_FUNCT = 2'b10
  } alu_mode_t;

  typedef enum logic [STATE_W-1:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_IRQ    = 4'd13
  } state_t;

  typedef struct packed {
    alu_mode_t alu_mode;
    logic      alu_src_a;
    src_b_t    alu_src_b;
    pc_src_t   pc_source;
    logic      pc_write;
    logic      is_branch;
    logic      lor_d;
    logic      mem_write;
    logic      ir_write;
    logic      reg_write;
    logic      reg_dst;
    logic      mem_to_reg;
    logic      is_interrupted;
    logic      irq_ack;
    logic      illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control: fixed ADD/SUB, or derived from the R-type funct field.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_mode_t            mode,
  input  logic [FUNCT_W-1:0]   funct,
  output alu_ctrl_t            alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (mode)
      MODE_SUB: alu_control = ALU_SUB;
      MODE_FUNCT: begin
        unique case (funct)
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          default:   alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath, with an edge-latched
// interrupt that is taken only at instruction boundaries.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               irq,
  output logic [ALU_W-1:0]   aluControl,
  output logic               aluSrcA,
  output logic [SEL_W-1:0]   aluSrcB,
  output logic [SEL_W-1:0]   PCSource,
  output logic               PCWrite,
  output logic               isBranch,
  output logic               lorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               isInterrupted,
  output logic               irq_ack,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t    state_q;
  state_t    state_d;
  ctrl_t     ctrl;
  logic      boundary;
  logic      irq_q;
  logic      irq_pend;
  alu_ctrl_t alu_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_START;
    else        state_q <= state_d;
  end

  // Rising edge of irq pends an interrupt; a new edge outranks the clear on IRQ entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q    <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      irq_q <= irq;
      if (irq && !irq_q)          irq_pend <= 1'b1;
      else if (state_d == S_IRQ)  irq_pend <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    boundary = 1'b0;
    ctrl     = '0;
    ctrl.alu_mode  = MODE_ADD;
    ctrl.alu_src_b = SRCB_B;
    ctrl.pc_source = PC_ALU;

    unique case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH, S_IRQ: begin
        ctrl.ir_write       = 1'b1;
        ctrl.alu_src_b      = SRCB_FOUR;
        ctrl.pc_write       = 1'b1;
        ctrl.is_interrupted = (state_q == S_IRQ);
        ctrl.irq_ack        = (state_q == S_IRQ);
        state_d             = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            ctrl.illegal_op = 1'b1;
            boundary        = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.lor_d = 1'b1;
        state_d    = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        boundary        = 1'b1;
      end
      S_MEMWR: begin
        ctrl.lor_d     = 1'b1;
        ctrl.mem_write = 1'b1;
        boundary       = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_mode  = MODE_FUNCT;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        boundary       = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_mode  = MODE_SUB;
        ctrl.pc_source = PC_ALUOUT;
        ctrl.is_branch = 1'b1;
        boundary       = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        boundary       = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PC_JUMP;
        ctrl.pc_write  = 1'b1;
        boundary       = 1'b1;
      end
      default: state_d = S_START;
    endcase

    if (boundary) state_d = irq_pend ? S_IRQ : S_FETCH;
  end

  alu_decoder u_alu_decoder (
    .mode        (ctrl.alu_mode),
    .funct       (funct),
    .alu_control (alu_ctrl)
  );

  assign aluControl    = alu_ctrl;
  assign aluSrcA       = ctrl.alu_src_a;
  assign aluSrcB       = ctrl.alu_src_b;
  assign PCSource      = ctrl.pc_source;
  assign PCWrite       = ctrl.pc_write;
  assign isBranch      = ctrl.is_branch;
  assign lorD          = ctrl.lor_d;
  assign MemWrite      = ctrl.mem_write;
  assign IRWrite       = ctrl.ir_write;
  assign RegWrite      = ctrl.reg_write;
  assign RegDst        = ctrl.reg_dst;
  assign MemtoReg      = ctrl.mem_to_reg;
  assign isInterrupted = ctrl.is_interrupted;
  assign irq_ack       = ctrl.irq_ack;
  assign illegal_op    = ctrl.illegal_op;
  assign state         = state_q;

endmodule
